aes_inv_sub_bytes_seq: RTL and testbench

Sequential inverse SubBytes unit for the AES decryption datapath. Accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes. It uses a single 32-bit inverse S-box word slice iterated over four cycles, trading latency for roughly a quarter of the LUT cost of a fully parallel inverse substitution. It sits between InvShiftRows and AddRoundKey in the decryption round pipeline and is the counterpart of the forward 128-bit S-box stage.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_inv_sbox.sv | 18 +
 rtl/aes_inv_sub_bytes_seq.sv | 91 +++++++++
 tb/tb_aes_inv_sub_bytes_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//   AES_WORDS    : number of 32-bit words in a 128-bit AES state
//   state_t      : control states of the sequential inverse SubBytes unit
//   AES_INV_SBOX : 256-entry inverse S-box lookup table
package aes_pkg;

  localparam int unsigned AES_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 32-bit inverse S-box slice: four parallel byte lookups.
//   word_in  : 32-bit word, byte b = word_in[8b+7:8b]
//   word_out : inverse-substituted word, same byte ordering
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  always_comb begin
    word_out = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word_out[8*b +: 8] = AES_INV_SBOX[word_in[8*b +: 8]];
    end
  end

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential inverse SubBytes: one 32-bit inverse S-box slice applied to
// the four words of a 128-bit state over four cycles, word 0 first.
//   sys_clk, sys_rst_n   : clock (rising edge), async active-low reset
//   in_valid/in_ready    : input handshake for data_in
//   data_in [127:0]      : state to substitute, byte k = data_in[8k+7:8k]
//   out_valid/out_ready  : output handshake for data_out
//   data_out [127:0]     : substituted state, meaningful while out_valid=1
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam logic [1:0] LAST_WORD = 2'(AES_WORDS - 1);

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [31:0]  sbox_in, sbox_out;

  // Word being substituted this cycle; {cnt,5'd0} is 32*cnt.
  assign sbox_in = work_q[{cnt_q, 5'd0} +: 32];

  aes_inv_sbox u_inv_sbox (
    .word_in  (sbox_in),
    .word_out (sbox_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = data_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d[{cnt_q, 5'd0} +: 32] = sbox_out;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_WORD) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Completing handshake frees the block, so a new state can be
        // taken on the same edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = data_in;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign data_out = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for aes_inv_sub_bytes_seq. The S-boxes are derived from GF(2^8)
// inversion plus the AES affine map; a transaction-level model predicts
// handshake and result, and a per-cycle compare checks the DUT against it.
module tb_aes_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  aes_inv_sub_bytes_seq dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] invsub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwdsub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  // Transaction model: an accepted state takes 4 edges to finish, then is
  // held until taken. m_left counts edges still owed.
  int           m_left  = 0;
  logic         m_valid = 1'b0;
  logic [127:0] m_data  = '0;

  function automatic logic model_rdy();
    return (m_left == 0 && !m_valid) || (m_valid && out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= (m_left == 1) || (m_valid && !out_ready);
      if (model_rdy() && in_valid) begin
        m_left <= 4;
        m_data <= invsub(data_in);
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input bit hold, output bit hs);
    bit acc, r;
    acc = 1'b0; hs = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r  = in_ready;
      hs = out_valid && out_ready;
      @(posedge clk);
      if (r) begin acc = 1'b1; break; end
    end
    #1;
    if (!hold) in_valid = 1'b0;
    check("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
    check("valid_latency", 128'(n), 128'(4));
  endtask

  initial begin
    int n;
    bit hs;
    logic [127:0] held, x, ya, yb;

    build_tables();
    check("model_inv_63", 128'(inv_tab[8'h63]), 128'h00);
    check("model_inv_16", 128'(inv_tab[8'h16]), 128'hff);
    check("model_inv_ed", 128'(inv_tab[8'hed]), 128'h53);
    check("model_inv_7c", 128'(inv_tab[8'h7c]), 128'h01);
    check("model_inv_00", 128'(inv_tab[8'h00]), 128'h52);
    check("model_fwd_53", 128'(fwd_tab[8'h53]), 128'hed);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_data_out", data_out, '0);

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          check("cyc_out_valid", 128'(out_valid), 128'(m_valid));
          check("cyc_in_ready", 128'(in_ready), 128'(model_rdy()));
          if (m_valid) check("cyc_data_out", data_out, m_data);
        end
      end
    join_none

    // All-0x63 state
    out_ready = 1'b1;
    send({16{8'h63}}, 1'b0, hs);
    wait_valid(n);
    check("all63_data", data_out, '0);

    // Byte mapping, then backpressure on its result
    send({96'h0, 32'h16ED7C63}, 1'b0, hs);
    out_ready = 1'b0;
    wait_valid(n);
    check("bytemap_data", data_out, {{3{32'h52525252}}, 32'hFF530100});
    held = data_out;
    in_valid = 1'b1;
    data_in  = 128'h0123456789abcdef_fedcba9876543210;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 128'(out_valid), 128'(1));
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_data", data_out, held);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_out_valid", 128'(out_valid), 128'(0));
    wait_valid(n);
    check("release_next_data", data_out, invsub(128'h0123456789abcdef_fedcba9876543210));

    // Back-to-back with out_ready held high
    ya = 128'h00112233445566778899aabbccddeeff;
    yb = 128'h63636363_16ED7C63_00000000_7C7C7C7C;
    send(ya, 1'b1, hs);
    send(yb, 1'b0, hs);
    check("b2b_accept_on_handshake", 128'(hs), 128'(1));
    wait_valid(n);
    check("b2b_second_data", data_out, 128'h00000000_FF530100_52525252_01010101);

    // Reset while cnt==2
    send(128'hdeadbeef_cafef00d_13579bdf_2468ace0, 1'b0, hs);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", 128'(in_ready), 128'(1));
    check("midreset_data_cleared", data_out, '0);
    send(yb, 1'b0, hs);
    wait_valid(n);
    check("after_reset_data", data_out, 128'h00000000_FF530100_52525252_01010101);

    // Round trip through the forward S-box model
    for (int t = 0; t < 1000; t++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(fwdsub(x), 1'b0, hs);
      wait_valid(n);
      check("roundtrip", data_out, x);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
